// File: rtl/user_ctrl_responder.sv
// AXI4-Lite control responder for the user partition: ID, start/done handshake,
// coherent 64-bit cycle counter, scratch registers and a level interrupt.
module user_ctrl_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] ID_VALUE    = 32'h5753_4831,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  user_start,
  input  logic                  user_busy,
  input  logic                  user_done,
  output logic                  irq
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam logic [AW-1:0] W_ID   = AW'(0);
  localparam logic [AW-1:0] W_CTRL = AW'(1);
  localparam logic [AW-1:0] W_STAT = AW'(2);
  localparam logic [AW-1:0] W_CLO  = AW'(3);
  localparam logic [AW-1:0] W_CHI  = AW'(4);
  localparam logic [AW-1:0] W_SCR  = AW'(8);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                        aw_full, w_full;
  logic [AW-1:0]               aw_idx;
  logic [31:0]                 w_data;
  logic [3:0]                  w_strb;
  logic                        irq_en, done;
  logic [63:0]                 cycle_cnt;
  logic [31:0]                 shadow;
  logic [NUM_SCRATCH-1:0][31:0] scratch;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0] ar_idx;
  logic [31:0]   rd_val;
  logic          rd_ok, wr_ok;
  logic          ctrl_wr, stat_wr;
  logic          unused;

  assign unused = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign s_axil_awready = !aw_full;
  assign s_axil_wready  = !w_full;
  assign s_axil_arready = !s_axil_rvalid;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = aw_full && w_full && !s_axil_bvalid;
  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];

  function automatic logic is_scratch(input logic [AW-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (idx == W_SCR + AW'(i)) hit = 1'b1;
    return hit;
  endfunction

  assign wr_ok   = (aw_idx <= W_CHI) || is_scratch(aw_idx);
  assign ctrl_wr = commit && (aw_idx == W_CTRL) && w_strb[0];
  assign stat_wr = commit && (aw_idx == W_STAT) && w_strb[0];

  // Read mux sees pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (ar_idx)
      W_ID:   rd_val = ID_VALUE;
      W_CTRL: rd_val = {30'd0, irq_en, 1'b0};
      W_STAT: rd_val = {30'd0, done, user_busy};
      W_CLO:  rd_val = cycle_cnt[31:0];
      W_CHI:  rd_val = shadow;
      default: begin
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (ar_idx == W_SCR + AW'(i)) begin
            rd_val = scratch[i];
            rd_ok  = 1'b1;
          end
      end
    endcase
  end

  // Write channel: independent AW/W holding slots, commit when both present.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_ok ? OKAY : SLVERR;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Read channel; a CYCLE_LO read latches the upper half for a later CYCLE_HI.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= OKAY;
      shadow        <= '0;
    end else begin
      if (ar_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_val;
        s_axil_rresp  <= rd_ok ? OKAY : SLVERR;
        if (ar_idx == W_CLO) shadow <= cycle_cnt[63:32];
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cycle_cnt  <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      user_start <= 1'b0;
      scratch    <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 64'd1;
      user_start <= ctrl_wr && w_data[0];
      irq        <= irq_en && done;
      if (ctrl_wr) irq_en <= w_data[1];
      if (user_done)                done <= 1'b1;
      else if (stat_wr && w_data[1]) done <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (commit && aw_idx == W_SCR + AW'(i))
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) scratch[i][8*b +: 8] <= w_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_user_ctrl_responder.sv
// Directed bench for user_ctrl_responder: register map, channel timing,
// counter snapshot, error decode and mid-transaction reset.
module tb_user_ctrl_responder;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [11:0] s_axil_awaddr, s_axil_araddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready;
  logic        user_start, user_busy, user_done, irq;

  int n_assert = 0;
  int n_fail   = 0;

  user_ctrl_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .user_start(user_start), .user_busy(user_busy), .user_done(user_done), .irq(irq)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    while (!s_axil_arready && n < 20) begin tick(); n++; end
    chk("rd_arready_timeout", 64'(n < 20), 1);
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    chk("rvalid_latency", s_axil_rvalid, 1);
    d = s_axil_rdata; r = s_axil_rresp;
    s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic done_at_commit, output logic [1:0] resp,
                    output logic st_commit, output logic st_after);
    int n = 0;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin tick(); n++; end
    chk("wr_ready_timeout", 64'(n < 20), 1);
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    chk("bvalid_early", s_axil_bvalid, 0);
    user_done = done_at_commit;
    tick();
    user_done = 1'b0;
    chk("bvalid_latency", s_axil_bvalid, 1);
    resp = s_axil_bresp; st_commit = user_start;
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    st_after = user_start;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        s0, s1;

    aresetn = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    user_busy = 1'b0; user_done = 1'b0;
    tick(); tick();
    aresetn = 1'b1;

    chk("rst_awready", s_axil_awready, 1);
    chk("rst_wready",  s_axil_wready, 1);
    chk("rst_arready", s_axil_arready, 1);
    chk("rst_bvalid",  s_axil_bvalid, 0);
    chk("rst_rvalid",  s_axil_rvalid, 0);
    chk("rst_rdata",   s_axil_rdata, 0);
    chk("rst_start",   user_start, 0);
    chk("rst_irq",     irq, 0);

    rd(12'h000, d, r);
    chk("id_data", d, 32'h5753_4831);
    chk("id_resp", r, 2'b00);

    // AW alone, W three cycles later, then a long bready stall.
    s_axil_awaddr = 12'h020; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    chk("aw_held_awready", s_axil_awready, 0);
    chk("aw_held_wready", s_axil_wready, 1);
    tick(); tick();
    s_axil_wdata = 32'hA5A5_1234; s_axil_wstrb = 4'b0101; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    chk("split_bvalid_c3", s_axil_bvalid, 0);
    tick();
    chk("split_bvalid_c4", s_axil_bvalid, 1);
    chk("split_bresp", s_axil_bresp, 2'b00);
    s_axil_awaddr = 12'h024; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", s_axil_bvalid, 1);
      chk("stall_bresp", s_axil_bresp, 2'b00);
      chk("stall_awready", s_axil_awready, 0);
      tick();
    end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    chk("stall_release_bvalid", s_axil_bvalid, 0);
    chk("stall_aw_still_held", s_axil_awready, 0);
    s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    tick();
    chk("second_bvalid", s_axil_bvalid, 1);
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    rd(12'h020, d, r);
    chk("scratch0_masked", d, 32'h00A5_0034);
    rd(12'h024, d, r);
    chk("scratch1_full", d, 32'hDEAD_BEEF);

    // START pulse, IRQ_EN, DONE and irq.
    wr(12'h004, 32'h3, 4'h1, 1'b0, r, s0, s1);
    chk("ctrl_bresp", r, 2'b00);
    chk("start_pulse", s0, 1);
    chk("start_one_cycle", s1, 0);
    rd(12'h004, d, r);
    chk("ctrl_read", d, 32'h2);
    chk("irq_before_done", irq, 0);
    user_done = 1'b1; tick(); user_done = 1'b0;
    chk("irq_lags_done", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    user_busy = 1'b1;
    rd(12'h008, d, r);
    chk("status_done_busy", d, 32'h3);
    user_busy = 1'b0;
    wr(12'h008, 32'h2, 4'h1, 1'b1, r, s0, s1);
    rd(12'h008, d, r);
    chk("done_set_wins", d, 32'h2);
    chk("irq_kept", irq, 1);
    wr(12'h008, 32'h2, 4'h1, 1'b0, r, s0, s1);
    chk("irq_cleared", irq, 0);
    rd(12'h008, d, r);
    chk("done_cleared", d, 32'h0);

    // Coherent counter read across a low-word wrap.
    force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    rd(12'h00C, d, r);
    release dut.cycle_cnt;
    chk("cycle_lo", d, 32'hFFFF_FFFF);
    tick(); tick();
    rd(12'h010, d, r);
    chk("cycle_hi_shadow", d, 32'h1);
    rd(12'h00C, d, r);
    rd(12'h010, d, r);
    chk("cycle_hi_carry", d, 32'h2);
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.cycle_cnt;
    tick(); tick();
    rd(12'h00C, d, r);
    rd(12'h010, d, r);
    chk("cycle_wrap_hi", d, 32'h0);

    // Unmapped offsets.
    rd(12'h100, d, r);
    chk("bad_rd_data", d, 32'h0);
    chk("bad_rd_resp", r, 2'b10);
    rd(12'h030, d, r);
    chk("past_scratch_resp", r, 2'b10);
    rd(12'h02C, d, r);
    chk("last_scratch_resp", r, 2'b00);
    wr(12'h104, 32'hFFFF_FFFF, 4'hF, 1'b0, r, s0, s1);
    chk("bad_wr_resp", r, 2'b10);
    chk("bad_wr_no_start", s0, 0);
    rd(12'h020, d, r);
    chk("bad_wr_scratch0", d, 32'h00A5_0034);
    rd(12'h004, d, r);
    chk("bad_wr_ctrl", d, 32'h2);

    // Reset with both responses outstanding.
    s_axil_awaddr = 12'h028; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h1111_2222; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_araddr = 12'h000; s_axil_arvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    tick();
    chk("pre_rst_bvalid", s_axil_bvalid, 1);
    chk("pre_rst_rvalid", s_axil_rvalid, 1);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_bvalid", s_axil_bvalid, 0);
    chk("mid_rst_rvalid", s_axil_rvalid, 0);
    chk("mid_rst_awready", s_axil_awready, 1);
    aresetn = 1'b1;
    rd(12'h020, d, r);
    chk("post_rst_scratch0", d, 32'h0);
    rd(12'h028, d, r);
    chk("post_rst_scratch2", d, 32'h0);
    rd(12'h004, d, r);
    chk("post_rst_ctrl", d, 32'h0);
    wr(12'h024, 32'h1234_5678, 4'hF, 1'b0, r, s0, s1);
    chk("post_rst_bresp", r, 2'b00);
    rd(12'h024, d, r);
    chk("post_rst_readback", d, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
